// File: rtl/seg_page_sched_if.sv
// Bundle between page sources, the override requester and the
// seven-segment page scheduler.
interface seg_page_sched_if;
   logic [63:0] page_num;
   logic [15:0] page_dot;
   logic [3:0]  page_en;
   logic        hold;
   logic        next;
   logic        ovr_req;
   logic [15:0] ovr_num;
   logic [3:0]  ovr_dot;
   logic        ovr_ack;
   logic        ovr_busy;
   logic [15:0] number;
   logic [3:0]  dot;
   logic [1:0]  page;
   logic        blank;

   modport master (
      output page_num, page_dot, page_en, hold, next, ovr_req, ovr_num, ovr_dot,
      input  ovr_ack, ovr_busy, number, dot, page, blank
   );

   modport slave (
      input  page_num, page_dot, page_en, hold, next, ovr_req, ovr_num, ovr_dot,
      output ovr_ack, ovr_busy, number, dot, page, blank
   );
endinterface

// File: rtl/seg_page_sched.sv
// Time-shares a 4-digit display between four pages and a priority override,
// producing registered number/dot/blank for the digit-scan multiplexer.
module seg_page_sched #(
   parameter int unsigned DWELL    = 50_000_000,
   parameter int unsigned OVR_HOLD = 100_000_000
) (
   input  logic             clk,
   input  logic             nrst,
   seg_page_sched_if.slave  bus
);
   localparam logic [31:0] DWELL_LD = 32'(DWELL - 1);
   localparam logic [31:0] OVR_LD   = 32'(OVR_HOLD - 1);

   typedef enum logic [1:0] {S_IDLE, S_SHOW, S_OVR} state_e;

   state_e      state_q, state_d;
   logic [1:0]  page_q, page_d;
   logic [31:0] tmr_q, tmr_d;
   logic [15:0] onum_q, onum_d;
   logic [3:0]  odot_q, odot_d;
   logic        accept;

   logic [15:0] number_q, number_d;
   logic [3:0]  dot_q, dot_d;
   logic        blank_q, blank_d;
   logic        ack_q, busy_q;

   // First enabled page searching p+off, p+off+1, ... (mod 4); p if none.
   function automatic logic [1:0] first_en(input logic [3:0] en,
                                           input logic [1:0] p,
                                           input logic [1:0] off);
      logic [1:0] k;
      first_en = p;
      for (int i = 3; i >= 0; i--) begin
         k = p + off + 2'(i);
         if (en[k]) first_en = k;
      end
   endfunction

   // NOTE: every register uses non-blocking assignments so all of them
   // update together from the same pre-edge values.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q  <= S_IDLE;
         page_q   <= 2'd0;
         tmr_q    <= DWELL_LD;
         onum_q   <= 16'h0;
         odot_q   <= 4'h0;
         number_q <= 16'h0;
         dot_q    <= 4'h0;
         blank_q  <= 1'b1;
         ack_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         page_q   <= page_d;
         tmr_q    <= tmr_d;
         onum_q   <= onum_d;
         odot_q   <= odot_d;
         number_q <= number_d;
         dot_q    <= dot_d;
         blank_q  <= blank_d;
         ack_q    <= accept;
         busy_q   <= (state_q == S_OVR);
      end
   end

   // NOTE: every always_comb target gets a default first, so no branch
   // can leave one unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      page_d  = page_q;
      tmr_d   = tmr_q;
      onum_d  = onum_q;
      odot_d  = odot_q;
      accept  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.ovr_req) begin
               accept = 1'b1;
            end else if (|bus.page_en) begin
               state_d = S_SHOW;
               page_d  = first_en(bus.page_en, page_q, 2'd0);
               tmr_d   = DWELL_LD;
            end
         end
         S_SHOW: begin
            if (bus.ovr_req) begin
               accept = 1'b1;
            end else if (bus.page_en == 4'b0) begin
               state_d = S_IDLE;
            end else if (!bus.page_en[page_q] || bus.next ||
                         (tmr_q == 32'd0 && !bus.hold)) begin
               page_d = first_en(bus.page_en, page_q, 2'd1);
               tmr_d  = DWELL_LD;
            end else if (!bus.hold) begin
               tmr_d = tmr_q - 32'd1;
            end
         end
         S_OVR: begin
            if (tmr_q == 32'd0) begin
               if (|bus.page_en) begin
                  state_d = S_SHOW;
                  page_d  = bus.page_en[page_q] ? page_q
                                                : first_en(bus.page_en, page_q, 2'd1);
                  tmr_d   = DWELL_LD;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               tmr_d = tmr_q - 32'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Accepting an override keeps the page so the display resumes there.
      if (accept) begin
         state_d = S_OVR;
         tmr_d   = OVR_LD;
         onum_d  = bus.ovr_num;
         odot_d  = bus.ovr_dot;
      end
   end

   always_comb begin
      number_d = 16'h0;
      dot_d    = 4'h0;
      blank_d  = 1'b1;
      case (state_q)
         S_SHOW: begin
            number_d = bus.page_num[{page_q, 4'b0000} +: 16];
            dot_d    = bus.page_dot[{page_q, 2'b00} +: 4];
            blank_d  = 1'b0;
         end
         S_OVR: begin
            number_d = onum_q;
            dot_d    = odot_q;
            blank_d  = 1'b0;
         end
         default: ;
      endcase
   end

   assign bus.ovr_ack  = ack_q;
   assign bus.ovr_busy = busy_q;
   assign bus.number   = number_q;
   assign bus.dot      = dot_q;
   assign bus.page     = page_q;
   assign bus.blank    = blank_q;
endmodule

// File: tb/tb_seg_page_sched.sv
// Self-checking bench for seg_page_sched: cycle model plus directed scenarios
// with hand-computed expectations (DWELL=4, OVR_HOLD=6).
module tb_seg_page_sched;
   localparam int DWELL    = 4;
   localparam int OVR_HOLD = 6;

   logic clk  = 1'b0;
   logic nrst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   seg_page_sched_if bus ();

   seg_page_sched #(.DWELL(DWELL), .OVR_HOLD(OVR_HOLD)) dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef enum {M_IDLE, M_SHOW, M_OVR} mode_e;
   mode_e       m_mode  = M_IDLE;
   int          m_page  = 0;
   int          m_age   = 0;   // cycles elapsed (non-held) on current page / override
   logic [15:0] m_onum  = '0;
   logic [3:0]  m_odot  = '0;
   logic [15:0] e_number = '0;
   logic [3:0]  e_dot    = '0;
   logic        e_blank  = 1'b1;
   logic        e_ack    = 1'b0;
   logic        e_busy   = 1'b0;

   function automatic int pick(input logic [3:0] en, input int p, input int off);
      for (int i = 0; i < 4; i++) begin
         int k;
         k = (p + off + i) % 4;
         if (en[k]) return k;
      end
      return p;
   endfunction

   always @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         m_mode = M_IDLE; m_page = 0; m_age = 0;
         e_number = '0; e_dot = '0; e_blank = 1'b1; e_ack = 1'b0; e_busy = 1'b0;
      end else begin
         bit acc;
         e_busy   = (m_mode == M_OVR);
         e_blank  = (m_mode == M_IDLE);
         e_number = (m_mode == M_SHOW) ? bus.page_num[m_page*16 +: 16] :
                    (m_mode == M_OVR)  ? m_onum : 16'h0;
         e_dot    = (m_mode == M_SHOW) ? bus.page_dot[m_page*4 +: 4] :
                    (m_mode == M_OVR)  ? m_odot : 4'h0;
         acc = 1'b0;
         case (m_mode)
            M_IDLE:
               if (bus.ovr_req) acc = 1'b1;
               else if (bus.page_en != 0) begin
                  m_mode = M_SHOW; m_page = pick(bus.page_en, m_page, 0); m_age = 0;
               end
            M_SHOW:
               if (bus.ovr_req) acc = 1'b1;
               else if (bus.page_en == 0) m_mode = M_IDLE;
               else if (!bus.page_en[m_page] || bus.next ||
                        (!bus.hold && m_age == DWELL - 1)) begin
                  m_page = pick(bus.page_en, m_page, 1); m_age = 0;
               end else if (!bus.hold) m_age++;
            M_OVR:
               if (m_age == OVR_HOLD - 1) begin
                  if (bus.page_en != 0) begin
                     m_mode = M_SHOW; m_age = 0;
                     if (!bus.page_en[m_page]) m_page = pick(bus.page_en, m_page, 1);
                  end else m_mode = M_IDLE;
               end else m_age++;
            default: ;
         endcase
         if (acc) begin
            m_mode = M_OVR; m_age = 0; m_onum = bus.ovr_num; m_odot = bus.ovr_dot;
         end
         e_ack = acc;
      end
   end

   always @(negedge clk) begin
      check("cmp_number", 32'(bus.number), 32'(e_number));
      check("cmp_dot",    32'(bus.dot),    32'(e_dot));
      check("cmp_blank",  32'(bus.blank),  32'(e_blank));
      check("cmp_ack",    32'(bus.ovr_ack), 32'(e_ack));
      check("cmp_busy",   32'(bus.ovr_busy), 32'(e_busy));
      check("cmp_page",   32'(bus.page),   32'(m_page));
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      nrst = 1'b0;
      bus.page_en = 4'b0; bus.hold = 1'b0; bus.next = 1'b0; bus.ovr_req = 1'b0;
      step(2);
      nrst = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int acks, busys, beefs;
      bus.page_num = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
      bus.page_dot = {4'h8, 4'h4, 4'h2, 4'h1};
      bus.page_en  = 4'b0; bus.hold = 1'b0; bus.next = 1'b0;
      bus.ovr_req  = 1'b0; bus.ovr_num = 16'h0; bus.ovr_dot = 4'h0;

      // Reset and enable: blank until pages enabled, then 0,2,0,2 every 4 cycles.
      #12 nrst = 1'b1;
      step(9);
      check("idle_blank", 32'(bus.blank), 32'd1);
      check("idle_number", 32'(bus.number), 32'd0);
      bus.page_en = 4'b0101;
      step(1);
      check("en_blank_lag", 32'(bus.blank), 32'd1);
      for (int i = 0; i < 12; i++) begin
         check("seq_page", 32'(bus.page), ((i / 4) % 2) ? 32'd2 : 32'd0);
         if (i == 1) check("seq_num0", 32'(bus.number), 32'h1111);
         if (i == 5) check("seq_num2", 32'(bus.number), 32'h3333);
         step(1);
      end

      // Hold and next.
      do_reset();
      bus.page_en = 4'b1111;
      step(1);
      bus.hold = 1'b1;
      step(3);
      check("hold_page0", 32'(bus.page), 32'd0);
      bus.next = 1'b1;
      step(1);
      bus.next = 1'b0;
      check("hold_next", 32'(bus.page), 32'd1);
      step(6);
      check("hold_stay", 32'(bus.page), 32'd1);
      bus.hold = 1'b0;
      step(3);
      check("rel_last", 32'(bus.page), 32'd1);
      step(1);
      check("rel_adv", 32'(bus.page), 32'd2);

      // Override while on page 2.
      bus.ovr_req = 1'b1; bus.ovr_num = 16'hBEEF; bus.ovr_dot = 4'b1010;
      step(1);
      acks = 0; busys = 0; beefs = 0;
      for (int i = 0; i <= 10; i++) begin
         if (bus.ovr_ack) acks++;
         if (bus.ovr_busy) begin
            busys++;
            if (bus.number == 16'hBEEF && bus.dot == 4'b1010) beefs++;
         end
         if (i == 3) bus.ovr_req = 1'b0;
         if (i == 9) check("ovr_ret_page", 32'(bus.page), 32'd2);
         if (i == 10) check("ovr_ret_next", 32'(bus.page), 32'd3);
         step(1);
      end
      check("ovr_acks", 32'(acks), 32'd1);
      check("ovr_busy_len", 32'(busys), 32'd6);
      check("ovr_beef", 32'(beefs), 32'd6);

      // Disable current page, then all pages.
      do_reset();
      bus.page_en = 4'b1111;
      step(1);
      bus.next = 1'b1;
      step(2);
      bus.next = 1'b0;
      check("dis_at2", 32'(bus.page), 32'd2);
      bus.page_en = 4'b1011;
      step(1);
      check("dis_adv3", 32'(bus.page), 32'd3);
      step(3);
      check("dis_reload", 32'(bus.page), 32'd3);
      step(1);
      check("dis_wrap0", 32'(bus.page), 32'd0);
      bus.page_en = 4'b0000;
      step(1);
      check("off_blank_lag", 32'(bus.blank), 32'd0);
      step(1);
      check("off_blank", 32'(bus.blank), 32'd1);
      check("off_number", 32'(bus.number), 32'd0);

      // Simultaneous next, tmr=0 and ovr_req; then next with tmr=0.
      do_reset();
      bus.page_en = 4'b1111;
      step(4);
      bus.next = 1'b1; bus.ovr_req = 1'b1; bus.ovr_num = 16'h1234; bus.ovr_dot = 4'h5;
      step(1);
      bus.next = 1'b0; bus.ovr_req = 1'b0;
      check("sim_ack", 32'(bus.ovr_ack), 32'd1);
      check("sim_page", 32'(bus.page), 32'd0);
      step(6);
      check("sim_ret", 32'(bus.page), 32'd0);
      step(3);
      bus.next = 1'b1;
      step(1);
      bus.next = 1'b0;
      check("single_adv", 32'(bus.page), 32'd1);
      step(3);
      check("single_hold", 32'(bus.page), 32'd1);
      step(1);
      check("single_next", 32'(bus.page), 32'd2);

      // Reset mid-override.
      do_reset();
      bus.page_en = 4'b0101; bus.ovr_req = 1'b1; bus.ovr_num = 16'hCAFE; bus.ovr_dot = 4'h3;
      step(1);
      check("rst_ack", 32'(bus.ovr_ack), 32'd1);
      bus.ovr_req = 1'b0;
      step(2);
      check("rst_busy_pre", 32'(bus.ovr_busy), 32'd1);
      check("rst_num_pre", 32'(bus.number), 32'hCAFE);
      nrst = 1'b0;
      #1;
      check("rst_busy", 32'(bus.ovr_busy), 32'd0);
      check("rst_blank", 32'(bus.blank), 32'd1);
      check("rst_page", 32'(bus.page), 32'd0);
      step(1);
      nrst = 1'b1;
      step(1);
      check("rst_restart_page", 32'(bus.page), 32'd0);
      check("rst_restart_blank", 32'(bus.blank), 32'd1);
      check("rst_no_ack", 32'(bus.ovr_ack), 32'd0);
      step(1);
      check("rst_restart_num", 32'(bus.number), 32'h1111);
      check("rst_restart_on", 32'(bus.blank), 32'd0);

      step(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
